alu_sequencer: RTL

Multi-cycle control unit that sequences the CPU register-file/ALU datapath from a stream of 16-bit instructions.
- Accepts one instruction per valid/ready handshake.
- Drives the datapath control inputs: ALUControl, readReg1, readReg2, writeReg, writeData, writeEnable.
- Captures ALUResult/Zero and commits the result through the register-file write port.
- Sits between an instruction source (bench or future fetch unit) and the CPU block.

---
 rtl/alu_sequencer.sv | 101 ++++++++++
 1 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: four-cycle control unit driving the register-file/ALU datapath from 16-bit instructions
module alu_sequencer #(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 4,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [15:0]        instr,
    output logic [3:0]         ALUControl,
    output logic [REG_AW-1:0]  readReg1,
    output logic [REG_AW-1:0]  readReg2,
    output logic [REG_AW-1:0]  writeReg,
    output logic [DATA_W-1:0]  writeData,
    output logic               writeEnable,
    input  logic [DATA_W-1:0]  ALUResult,
    input  logic               Zero,
    output logic               zero_flag,
    output logic               done,
    output logic               illegal,
    output logic [COUNT_W-1:0] instr_count
);
    typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;

    state_t      state, next;
    logic [15:0] ir;
    logic        zero_cap;
    logic [3:0]  op;
    logic        is_alu, is_ldi, is_cmp, is_nop, is_ill, accept;

    assign op     = ir[15:12];
    assign is_alu = ~op[3];
    assign is_ldi = op == 4'h8;
    assign is_cmp = op == 4'h9;
    assign is_nop = op == 4'hF;
    assign is_ill = op[3] & ~is_ldi & ~is_cmp & ~is_nop;
    assign accept = instr_valid & instr_ready;

    // State register; reset discards any in-flight instruction
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next;
    end

    // Fixed DECODE -> EXEC -> WB walk once an instruction is accepted
    always_comb begin
        next        = state;
        instr_ready = 1'b0;
        case (state)
            IDLE: begin
                instr_ready = 1'b1;
                next        = instr_valid ? DECODE : IDLE;
            end
            DECODE: next = EXEC;
            EXEC:   next = WB;
            default: next = IDLE;
        endcase
    end

    // Datapath controls: sources and ALU op set at accept, result captured at end of EXEC, commit during WB
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ir          <= '0;
            zero_cap    <= 1'b0;
            ALUControl  <= '0;
            readReg1    <= '0;
            readReg2    <= '0;
            writeReg    <= '0;
            writeData   <= '0;
            writeEnable <= 1'b0;
            zero_flag   <= 1'b0;
            done        <= 1'b0;
            illegal     <= 1'b0;
            instr_count <= '0;
        end else begin
            if (accept) begin
                ir         <= instr;
                readReg1   <= REG_AW'(instr[7:4]);
                readReg2   <= REG_AW'(instr[3:0]);
                ALUControl <= !instr[15] ? instr[15:12] : instr[15:12] == 4'h9 ? 4'h1 : ALUControl;
            end
            if (state == EXEC) begin
                zero_cap    <= Zero;
                writeReg    <= REG_AW'(ir[11:8]);
                writeData   <= is_ldi ? DATA_W'(ir[7:0]) : is_alu ? ALUResult : writeData;
                writeEnable <= is_alu | is_ldi;
                done        <= 1'b1;
                illegal     <= is_ill;
            end
            if (state == WB) begin
                writeEnable <= 1'b0;
                done        <= 1'b0;
                illegal     <= 1'b0;
                zero_flag   <= (is_alu | is_cmp) ? zero_cap : zero_flag;
                instr_count <= is_ill ? instr_count : instr_count + 1'b1;
            end
        end
    end
endmodule
